edge_generator: RTL and testbench

Inverse of the edge detector: turns single-cycle rising/falling edge requests into a clean registered level on `a_o`. It enforces minimum high and low dwell times and queues one deferred request per hold window. It emits `rising_edge_o`/`falling_edge_o` pulses aligned with each level change, so a downstream edge detector reproduces the accepted request stream. It sits in front of any pin or handshake line that must be driven glitch-free from event logic.

---
 rtl/edge_gen_pkg.sv | 20 ++
 rtl/edge_generator_if.sv | 22 ++
 rtl/edge_generator_hold_timer.sv | 29 ++
 rtl/edge_generator.sv | 170 +++++++++++++++++
 tb/tb_edge_generator.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge generator: FSM state encoding and
// hold-counter sizing.
package edge_gen_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        LOW_HOLD  = 2'd1,
        HIGH      = 2'd2,
        HIGH_HOLD = 2'd3
    } edge_gen_state_e;

    function automatic int cnt_width(input int min_high, input int min_low);
        int m;
        int w;
        m = (min_high > min_low) ? min_high : min_low;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_generator_if.sv
// Request/level bundle between event logic and the edge generator.
interface edge_generator_if;

    logic rise_req_i;
    logic fall_req_i;
    logic a_o;
    logic rising_edge_o;
    logic falling_edge_o;
    logic busy_o;
    logic drop_o;

    modport slave (
        input  rise_req_i, fall_req_i,
        output a_o, rising_edge_o, falling_edge_o, busy_o, drop_o
    );

    modport master (
        output rise_req_i, fall_req_i,
        input  a_o, rising_edge_o, falling_edge_o, busy_o, drop_o
    );

endinterface

// File: rtl/edge_generator_hold_timer.sv
// Loadable down-counter that stops at zero; it only restarts when reloaded.
module hold_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;

    // Count state: load on an edge, otherwise decrement down to zero and hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/edge_generator.sv
// Turns one-cycle rise/fall requests into a registered level with minimum
// high/low dwell times, a one-deep deferred request and aligned edge pulses.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    edge_generator_if.slave      bus
);

    localparam int CW = cnt_width(MIN_HIGH, MIN_LOW);
    localparam logic [CW-1:0] HIGH_RELOAD = CW'(MIN_HIGH - 1);
    localparam logic [CW-1:0] LOW_RELOAD  = CW'(MIN_LOW - 1);

    edge_gen_state_e state_q, state_d;
    logic            pending_q, pending_d;
    logic            a_q, rise_q, fall_q, busy_q, drop_q;
    logic            rise_d, fall_d, drop_d;
    logic            tmr_load, tmr_zero;
    logic [CW-1:0]   tmr_val;
    logic            both_s, rise_only_s, fall_only_s;
    logic            opp_s, same_s, pend_eff_s;

    hold_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign both_s      = bus.rise_req_i & bus.fall_req_i;
    assign rise_only_s = bus.rise_req_i & ~bus.fall_req_i;
    assign fall_only_s = bus.fall_req_i & ~bus.rise_req_i;

    // Next-state decode: request classification, pending update and edge launch.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        drop_d     = 1'b0;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = {CW{1'b0}};
        opp_s      = 1'b0;
        same_s     = 1'b0;
        pend_eff_s = pending_q;

        case (state_q)
            LOW, LOW_HOLD: begin
                opp_s  = rise_only_s;
                same_s = fall_only_s;
            end
            HIGH, HIGH_HOLD: begin
                opp_s  = fall_only_s;
                same_s = rise_only_s;
            end
            default: begin
                opp_s  = 1'b0;
                same_s = 1'b0;
            end
        endcase

        case (state_q)
            LOW, HIGH: begin
                if (both_s || same_s) begin
                    drop_d = 1'b1;
                end else if (opp_s) begin
                    pend_eff_s = 1'b1;
                end else begin
                    pend_eff_s = 1'b0;
                end
            end
            LOW_HOLD, HIGH_HOLD: begin
                // A second opposite request is a duplicate; a same-direction one cancels.
                if (both_s) begin
                    drop_d = 1'b1;
                end else if (opp_s) begin
                    drop_d     = pending_q;
                    pend_eff_s = 1'b1;
                end else if (same_s) begin
                    drop_d     = 1'b1;
                    pend_eff_s = 1'b0;
                end else begin
                    pend_eff_s = pending_q;
                end
            end
            default: begin
                pend_eff_s = 1'b0;
            end
        endcase

        case (state_q)
            LOW, HIGH: begin
                pending_d = 1'b0;
            end
            LOW_HOLD, HIGH_HOLD: begin
                if (tmr_zero) begin
                    pending_d = 1'b0;
                end else begin
                    pending_d = pend_eff_s;
                end
            end
            default: begin
                pending_d = 1'b0;
            end
        endcase

        case (state_q)
            LOW, LOW_HOLD: begin
                if (pend_eff_s && (state_q == LOW || tmr_zero)) begin
                    state_d  = HIGH_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HIGH_RELOAD;
                    rise_d   = 1'b1;
                end else if (state_q == LOW_HOLD && tmr_zero) begin
                    state_d = LOW;
                end else begin
                    state_d = state_q;
                end
            end
            HIGH, HIGH_HOLD: begin
                if (pend_eff_s && (state_q == HIGH || tmr_zero)) begin
                    state_d  = LOW_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LOW_RELOAD;
                    fall_d   = 1'b1;
                end else if (state_q == HIGH_HOLD && tmr_zero) begin
                    state_d = HIGH;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = LOW;
            end
        endcase
    end

    // State, pending flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOW;
            pending_q <= 1'b0;
            a_q       <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            a_q       <= (state_d == HIGH) || (state_d == HIGH_HOLD);
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= (state_d == LOW_HOLD) || (state_d == HIGH_HOLD);
            drop_q    <= drop_d;
        end
    end

    assign bus.a_o            = a_q;
    assign bus.rising_edge_o  = rise_q;
    assign bus.falling_edge_o = fall_q;
    assign bus.busy_o         = busy_q;
    assign bus.drop_o         = drop_q;

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator (MIN_HIGH=4, MIN_LOW=3): a per-cycle
// vector table plus hand-written dwell-time sequences.
module tb_edge_generator;

    typedef struct packed {
        logic chk;
        logic rst;
        logic rise;
        logic fall;
        logic a;
        logic re;
        logic fe;
        logic busy;
        logic drop;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs[$];

    edge_generator_if bus();

    edge_generator #(.MIN_HIGH(4), .MIN_LOW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic chk, input logic rst, input logic r,
                                input logic f, input logic a, input logic re,
                                input logic fe, input logic b, input logic d);
        vec_t v;
        v = '{chk, rst, r, f, a, re, fe, b, d};
        return v;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0b want %0b", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.rise_req_i = 1'b0;
        bus.fall_req_i = 1'b0;

        // A: rise 5, fall 7 (pending), rise 11 (pending), rise 12 (duplicate)
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_idle(4);
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c5
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); // c6
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c7
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c8
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c9
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); // c10
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); // c11
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); // c12
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1)); // c13
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c14-16
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); // c17
        // B: fall from reset state at 5, rise+fall at 8
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add_idle(4);
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c5
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); // c6
        add_idle(1);
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c8
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); // c9
        add_idle(1);
        // C: rise 5, fall 6, rise 7 cancels; then redundant rise in HIGH at 11
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_idle(4);
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c5
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); // c6
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c7
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1)); // c8
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c9
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); // c10
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); // c11
        // D: rise 5, fall 6, reset 8, rise 10
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        add_idle(4);
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c5
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); // c6
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c7
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c8
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c9
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); // c10
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); // c11
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); // c12

        // Each row: check outputs of the current cycle, then drive its inputs.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            if (vecs[i].chk) begin
                check("a_o",            i, bus.a_o,            vecs[i].a);
                check("rising_edge_o",  i, bus.rising_edge_o,  vecs[i].re);
                check("falling_edge_o", i, bus.falling_edge_o, vecs[i].fe);
                check("busy_o",         i, bus.busy_o,         vecs[i].busy);
                check("drop_o",         i, bus.drop_o,         vecs[i].drop);
            end
            reset          = vecs[i].rst;
            bus.rise_req_i = vecs[i].rise;
            bus.fall_req_i = vecs[i].fall;
        end

        // Dwell sequence: pending fall gives exactly MIN_HIGH high cycles,
        // pending rise gives exactly MIN_LOW low cycles.
        @(posedge clk); #1;
        reset = 1'b1; bus.rise_req_i = 1'b0; bus.fall_req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; bus.rise_req_i = 1'b1;
        @(posedge clk); #1;
        bus.rise_req_i = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.a_o !== 1'b1) break;
            n++;
            bus.fall_req_i = (k == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        bus.fall_req_i = 1'b0;
        check_int("high_dwell", n, 4);
        check("fall_pulse_at_drop", 0, bus.falling_edge_o, 1'b1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.a_o !== 1'b0) break;
            n++;
            bus.rise_req_i = (k == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        bus.rise_req_i = 1'b0;
        check_int("low_dwell", n, 3);
        check("rise_pulse_after_low", 0, bus.rising_edge_o, 1'b1);
        check("no_drop_in_dwell", 0, bus.drop_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
